// File: rtl/sketch_pkg.sv
// Shared types and default widths for the sketch pipeline head/tail controller.
package sketch_pkg;

    localparam int PKG_ADDR_W         = 16;
    localparam int PKG_DATA_W         = 16;
    localparam int PKG_PIPELINE_DEPTH = 2;
    localparam int DST_W              = $clog2(PKG_PIPELINE_DEPTH);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        SWEEP = 2'd2,
        DRAIN = 2'd3
    } sketch_state_t;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_DATA_W-1:0] data;
        logic                  is_readout;
    } sketch_report_t;

endpackage

// File: rtl/sketch_sync_fifo.sv
// Single-clock FIFO; output word is read straight from registered storage and forced to 0 when empty.
module sketch_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot the simultaneous push lands in, so full+push+pop is legal.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sketch_pipeline_driver.sv
// Head/tail controller for the sketch segment chain: credit-gated issue, readout sweep,
// and buffered reporting of hot counters and readout results.
module sketch_pipeline_driver
    import sketch_pkg::*;
#(
    parameter int ADDR_WIDTH_FULL = 16,
    parameter int ADDR_WIDTH      = 15,
    parameter int DATA_WIDTH      = 16,
    parameter int PIPELINE_DEPTH  = 2,
    parameter int HOT_THRESHOLD   = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int INIT_CYCLES     = (2**ADDR_WIDTH >> 5) + 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ADDR_WIDTH_FULL-1:0]        in_addr,
    input  logic                              sweep_start,
    output logic                              sweep_busy,
    output logic                              sweep_done,
    output logic [ADDR_WIDTH_FULL-1:0]        seg_addr,
    output logic                              seg_rd_en,
    output logic [$clog2(PIPELINE_DEPTH)-1:0] seg_dst_id,
    output logic                              seg_rd_cnt,
    input  logic [DATA_WIDTH-1:0]             tail_data,
    input  logic                              tail_valid,
    input  logic [ADDR_WIDTH_FULL-1:0]        tail_addr,
    input  logic                              tail_cnt_valid,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ADDR_WIDTH_FULL-1:0]        out_addr,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_is_readout
);
    localparam int ID_W   = $clog2(PIPELINE_DEPTH);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int REP_W  = ADDR_WIDTH_FULL + DATA_WIDTH + 1;

    sketch_state_t              state;
    sketch_state_t              state_next;
    logic [INIT_W-1:0]          init_cnt;
    logic [CW-1:0]              inflight;
    logic [CW-1:0]              fifo_count;
    logic [CW:0]                credit_sum;
    logic [ADDR_WIDTH_FULL-1:0] sweep_cnt;
    logic [ADDR_WIDTH_FULL-1:0] issue_addr;
    logic                       credit_ok;
    logic                       in_fire;
    logic                       sweep_fire;
    logic                       issue;
    logic                       tail_take;
    logic                       fifo_push;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [REP_W-1:0]           push_word;
    logic [REP_W-1:0]           pop_word;

    // Every issued request holds a FIFO slot until its result is dropped or popped.
    assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit_ok  = !fifo_full && (credit_sum < (CW+1)'(FIFO_DEPTH));
    assign in_fire    = in_valid && in_ready;
    assign sweep_fire = (state == SWEEP) && credit_ok;
    assign issue      = in_fire || sweep_fire;
    assign issue_addr = sweep_fire ? sweep_cnt : in_addr;

    assign tail_take  = tail_valid && (state != INIT);
    assign fifo_push  = tail_take &&
                        (tail_cnt_valid || (tail_data == DATA_WIDTH'(HOT_THRESHOLD)));
    assign push_word  = {tail_addr, tail_data, tail_cnt_valid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            init_cnt  <= '0;
            inflight  <= '0;
            sweep_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) init_cnt <= init_cnt + 1'b1;
            if (sweep_fire)    sweep_cnt <= sweep_cnt + 1'b1;
            case ({issue, tail_take})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            INIT:  if (init_cnt == INIT_W'(INIT_CYCLES - 1)) state_next = RUN;
            RUN:   if (sweep_start) state_next = SWEEP;
            SWEEP: if (sweep_fire && (sweep_cnt == '1)) state_next = DRAIN;
            DRAIN: if (inflight == '0) state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        in_ready   = (state == RUN) && credit_ok;
        sweep_busy = (state == SWEEP) || (state == DRAIN);
        sweep_done = (state == DRAIN) && (inflight == '0);
    end

    // Chain-head register stage: one cycle from issue decision to segment request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_rd_en  <= 1'b0;
            seg_rd_cnt <= 1'b0;
            seg_addr   <= '0;
            seg_dst_id <= '0;
        end else begin
            seg_rd_en  <= issue;
            seg_rd_cnt <= sweep_fire;
            if (issue) begin
                seg_addr   <= issue_addr;
                seg_dst_id <= issue_addr[ADDR_WIDTH +: ID_W];
            end
        end
    end

    sketch_sync_fifo #(
        .WIDTH (REP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_word),
        .pop       (out_ready),
        .pop_data  (pop_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid      = !fifo_empty;
    assign out_addr       = pop_word[REP_W-1 -: ADDR_WIDTH_FULL];
    assign out_data       = pop_word[DATA_WIDTH:1];
    assign out_is_readout = pop_word[0];

endmodule
